cell_reassign_buffer: RTL and testbench
=======================================

// Module: cell_reassign_buffer
// PURPOSE
//  Downstream of the cell-index stage. Accepts {cell index, wrapped position} per particle after the
//  position update and bins each particle into its new cell bucket (27 cells, 3x3x3).
//  Double-buffered: one bank fills for timestep n+1 while the force pipeline reads the committed bank.
//  A commit handshake swaps banks at the timestep boundary.
// PARAMETERS
//  NCELL   27  number of cells; legal cell index 0..NCELL-1
//  DEPTH   16  particle slots per cell per bank (power of 2)
//  SW      4   slot index width = log2(DEPTH)
// PORTS
//  clk         in   1    single clock, rising edge
//  rst_n       in   1    asynchronous active-low reset
//  in_valid    in   1    upstream particle valid
//  in_ready    out  1    block can accept this cycle
//  in_cidx     in   33   [31:0] cell index (unsigned int), [32] null flag (1 = no particle)
//  in_pos      in   97   [95:0] {z,y,x} fp32 wrapped position, [96] null flag (ignored; in_cidx[32] rules)
//  commit_req  in   1    level; request bank swap
//  commit_done out  1    1-cycle pulse when swap completes
//  rd_en       in   1    read request on committed bank
//  rd_cell     in   5    cell to read
//  rd_slot     in   SW   slot to read
//  rd_valid    out  1    read response valid (1 cycle after rd_en)
//  rd_hit      out  1    1 = rd_slot < committed count of rd_cell
//  rd_data     out  96   slot position; 0 when rd_hit=0
//  rd_count    out  SW+1 committed count of rd_cell
//  overflow    out  1    sticky: particle dropped due to full cell; cleared by reset only
//  range_err   out  1    sticky: in_cidx[31:0] >= NCELL seen; cleared by reset only
// BEHAVIOUR
//  Reset: state=FILL, write bank=0, all counts (both banks) 0, in_ready=0 during reset then 1,
//   commit_done/rd_valid/rd_hit/overflow/range_err=0, rd_data=0, rd_count=0.
//  FSM FILL -> FLUSH -> SWAP -> FILL.
//   FILL: in_ready = !commit_req. commit_req=1 -> FLUSH.
//   FLUSH (1 cycle): in_ready=0; pending write stage completes.
//   SWAP (1 cycle): in_ready=0; committed counts <= write counts; write counts <= 0; write bank flips;
//    commit_done=1 for this cycle. Then FILL. commit_req still high in FILL starts another swap.
//  Accept = in_valid & in_ready. Accepted item registered in cycle t; memory write and count++ at
//   end of cycle t+1. Back-to-back accepts to the same cell take consecutive slots (count forwarded).
//  Null item (in_cidx[32]=1): accepted, discarded, no flag.
//  in_cidx[31:0] >= NCELL: accepted, discarded, range_err set.
//  Cell count == DEPTH: accepted, discarded, overflow set; count saturates at DEPTH.
//  Read: rd_en sampled at edge t selects committed bank as of before that edge; response at t+1.
//   rd_cell >= NCELL -> rd_hit=0, rd_count=0, rd_data=0. rd_valid=0 when rd_en=0 (other outputs hold).
//  Read and fill banks never alias; read during SWAP returns pre-swap committed data.
//  Reset mid-fill or mid-swap: all contents discarded, returns to reset state; no commit_done.
//  Memory contents not reset; only counts gate visibility.
// CONFIGURATION
//  CELL_REASSIGN_STATS_EN defined: adds outputs stat_acc (32b, accepted non-null in-range items),
//   stat_drop (32b, overflow + range drops), stat_null (32b, null items); all reset to 0, wrap at 2^32,
//   cleared on SWAP after being copied to stat_*_last (32b each).
//  Not defined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  Reset then rd_en cell 0 slot 0 -> rd_valid=1, rd_hit=0, rd_count=0, rd_data=0.
//  3 items cidx=5 pos x=1.0,2.0,3.0, commit -> commit_done 2 cycles after commit_req sampled;
//   read cell 5 slots 0..2 -> 3F800000,40000000,40400000 in x field, rd_count=3, slot 3 rd_hit=0.
//  17 items to cell 26 -> overflow=1, rd_count=16 after commit, slot 15 holds 16th item.
//  cidx=27 and cidx=0x100000000 (null) -> range_err=1 for first only; no counts change.
//  Fill bank B while reading bank A -> reads return bank A data until commit_done, bank B after.
//  commit_req held while in_valid streaming -> in_ready=0 in FLUSH/SWAP, no item lost or duplicated.

Source files
------------

// File: rtl/cell_reassign_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cell_reassign_buffer
// Purpose  : Double-buffered 27-cell particle binning buffer with a commit
//            handshake that swaps the fill and read banks. Defining
//            CELL_REASSIGN_STATS_EN adds per-timestep statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module cell_reassign_buffer #(
    parameter int NCELL = 27,
    parameter int DEPTH = 16,
    parameter int SW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [32:0]   in_cidx,
    input  logic [96:0]   in_pos,
    input  logic          commit_req,
    output logic          commit_done,
    input  logic          rd_en,
    input  logic [4:0]    rd_cell,
    input  logic [SW-1:0] rd_slot,
    output logic          rd_valid,
    output logic          rd_hit,
    output logic [95:0]   rd_data,
    output logic [SW:0]   rd_count,
    output logic          overflow,
    output logic          range_err
`ifdef CELL_REASSIGN_STATS_EN
    ,
    output logic [31:0]   stat_acc,
    output logic [31:0]   stat_drop,
    output logic [31:0]   stat_null,
    output logic [31:0]   stat_acc_last,
    output logic [31:0]   stat_drop_last,
    output logic [31:0]   stat_null_last
`endif
);

    localparam int c_CW     = 5;
    localparam int c_MEM_AW = 1 + c_CW + SW;

    localparam logic [SW:0] c_CNT_FULL = (SW+1)'(DEPTH);
    localparam logic [SW:0] c_CNT_ONE  = (SW+1)'(1);

    localparam logic [1:0] c_S_FILL  = 2'd0;
    localparam logic [1:0] c_S_FLUSH = 2'd1;
    localparam logic [1:0] c_S_SWAP  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_in_ready;
    logic        w_commit_done;
    logic        r_live;
    logic        r_wbank;
    logic        w_swap;
    logic        w_accept;

    logic        r_s1_valid;
    logic        r_s1_null;
    logic [31:0] r_s1_cidx;
    logic [95:0] r_s1_pos;

    logic              w_s1_inrange;
    logic [c_CW-1:0]   w_s1_cell;
    logic [SW:0]       w_s1_cnt;
    logic              w_s1_full;
    logic              w_s1_write;
    logic              w_s1_ovf;
    logic              w_s1_rng;

    logic [SW:0]  w_wcnt [NCELL];
    logic [SW:0]  w_ccnt [NCELL];
    logic [95:0]  r_mem  [0:(2**c_MEM_AW)-1];

    logic              w_rd_ok;
    logic [c_CW-1:0]   w_rd_cell;
    logic [SW:0]       w_rd_cnt;
    logic              w_rd_hit;
    logic [95:0]       w_rd_word;

    logic        r_rd_valid;
    logic        r_rd_hit;
    logic [95:0] r_rd_data;
    logic [SW:0] r_rd_count;
    logic        r_overflow;
    logic        r_range_err;

    // The position null flag carries no information; the cell index flag rules.
    logic w_unused_pos_null;
    assign w_unused_pos_null = in_pos[96];

    // ------------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_FILL;
            r_live  <= 1'b0;
            r_wbank <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_live  <= 1'b1;
            if (w_swap) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_in_ready    = 1'b0;
        w_commit_done = 1'b0;
        case (r_state)
            c_S_FILL: begin
                w_in_ready = r_live & ~commit_req;
                if (commit_req) begin
                    w_next_state = c_S_FLUSH;
                end
            end
            c_S_FLUSH: begin
                w_next_state = c_S_SWAP;
            end
            c_S_SWAP: begin
                w_commit_done = 1'b1;
                w_next_state  = c_S_FILL;
            end
            default: begin
                w_next_state = c_S_FILL;
            end
        endcase
    end

    assign w_swap      = (r_state == c_S_SWAP);
    assign w_accept    = in_valid & w_in_ready;
    assign in_ready    = w_in_ready;
    assign commit_done = w_commit_done;

    // ------------------------------------------------------------------------
    // Input register stage; classification and write happen one cycle later
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_null <= in_cidx[32];
            r_s1_cidx <= in_cidx[31:0];
            r_s1_pos  <= in_pos[95:0];
        end
    end

    assign w_s1_inrange = (r_s1_cidx < 32'(NCELL));
    assign w_s1_cell    = w_s1_inrange ? r_s1_cidx[c_CW-1:0] : '0;
    assign w_s1_cnt     = w_wcnt[w_s1_cell];
    assign w_s1_full    = (w_s1_cnt == c_CNT_FULL);
    assign w_s1_write   = r_s1_valid & ~r_s1_null & w_s1_inrange & ~w_s1_full;
    assign w_s1_ovf     = r_s1_valid & ~r_s1_null & w_s1_inrange & w_s1_full;
    assign w_s1_rng     = r_s1_valid & ~r_s1_null & ~w_s1_inrange;

    // ------------------------------------------------------------------------
    // Per-cell fill and committed counts
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < NCELL; g++) begin : g_cell
        logic [SW:0] r_wcnt;
        logic [SW:0] r_ccnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wcnt <= '0;
                r_ccnt <= '0;
            end else if (w_swap) begin
                r_ccnt <= r_wcnt;
                r_wcnt <= '0;
            end else if (w_s1_write && (w_s1_cell == c_CW'(g))) begin
                r_wcnt <= r_wcnt + c_CNT_ONE;
            end
        end

        assign w_wcnt[g] = r_wcnt;
        assign w_ccnt[g] = r_ccnt;
    end

    // Both banks share one array; the bank bit is the address MSB.
    always_ff @(posedge clk) begin
        if (w_s1_write) begin
            r_mem[{r_wbank, w_s1_cell, w_s1_cnt[SW-1:0]}] <= r_s1_pos;
        end
    end

    // ------------------------------------------------------------------------
    // Read port on the committed bank
    // ------------------------------------------------------------------------
    assign w_rd_ok   = (rd_cell < c_CW'(NCELL));
    assign w_rd_cell = w_rd_ok ? rd_cell : '0;
    assign w_rd_cnt  = w_rd_ok ? w_ccnt[w_rd_cell] : '0;
    assign w_rd_hit  = ({1'b0, rd_slot} < w_rd_cnt);
    assign w_rd_word = r_mem[{~r_wbank, w_rd_cell, rd_slot}];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid  <= 1'b0;
            r_rd_hit    <= 1'b0;
            r_rd_data   <= '0;
            r_rd_count  <= '0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_hit   <= w_rd_hit;
                r_rd_count <= w_rd_cnt;
                r_rd_data  <= w_rd_hit ? w_rd_word : '0;
            end
            r_overflow  <= r_overflow | w_s1_ovf;
            r_range_err <= r_range_err | w_s1_rng;
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_hit    = r_rd_hit;
    assign rd_data   = r_rd_data;
    assign rd_count  = r_rd_count;
    assign overflow  = r_overflow;
    assign range_err = r_range_err;

`ifdef CELL_REASSIGN_STATS_EN
    logic [31:0] r_stat_acc;
    logic [31:0] r_stat_drop;
    logic [31:0] r_stat_null;
    logic [31:0] r_stat_acc_last;
    logic [31:0] r_stat_drop_last;
    logic [31:0] r_stat_null_last;

    // No item is in flight during SWAP, so the snapshot never races an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_acc       <= '0;
            r_stat_drop      <= '0;
            r_stat_null      <= '0;
            r_stat_acc_last  <= '0;
            r_stat_drop_last <= '0;
            r_stat_null_last <= '0;
        end else if (w_swap) begin
            r_stat_acc_last  <= r_stat_acc;
            r_stat_drop_last <= r_stat_drop;
            r_stat_null_last <= r_stat_null;
            r_stat_acc       <= '0;
            r_stat_drop      <= '0;
            r_stat_null      <= '0;
        end else begin
            if (w_s1_write) begin
                r_stat_acc <= r_stat_acc + 32'd1;
            end
            if (w_s1_ovf | w_s1_rng) begin
                r_stat_drop <= r_stat_drop + 32'd1;
            end
            if (r_s1_valid & r_s1_null) begin
                r_stat_null <= r_stat_null + 32'd1;
            end
        end
    end

    assign stat_acc       = r_stat_acc;
    assign stat_drop      = r_stat_drop;
    assign stat_null      = r_stat_null;
    assign stat_acc_last  = r_stat_acc_last;
    assign stat_drop_last = r_stat_drop_last;
    assign stat_null_last = r_stat_null_last;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cell_reassign_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_reassign_buffer
// Purpose  : Directed and randomized bench for cell_reassign_buffer against a
//            bank/queue level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_reassign_buffer;

    localparam int NCELL = 27;
    localparam int DEPTH = 16;
    localparam int SW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [32:0]   in_cidx;
    logic [96:0]   in_pos;
    logic          commit_req;
    logic          commit_done;
    logic          rd_en;
    logic [4:0]    rd_cell;
    logic [SW-1:0] rd_slot;
    logic          rd_valid;
    logic          rd_hit;
    logic [95:0]   rd_data;
    logic [SW:0]   rd_count;
    logic          overflow;
    logic          range_err;
`ifdef CELL_REASSIGN_STATS_EN
    logic [31:0]   stat_acc, stat_drop, stat_null;
    logic [31:0]   stat_acc_last, stat_drop_last, stat_null_last;
`endif

    always #5 clk = ~clk;

    cell_reassign_buffer #(.NCELL(NCELL), .DEPTH(DEPTH), .SW(SW)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cidx     (in_cidx),
        .in_pos      (in_pos),
        .commit_req  (commit_req),
        .commit_done (commit_done),
        .rd_en       (rd_en),
        .rd_cell     (rd_cell),
        .rd_slot     (rd_slot),
        .rd_valid    (rd_valid),
        .rd_hit      (rd_hit),
        .rd_data     (rd_data),
        .rd_count    (rd_count),
        .overflow    (overflow),
        .range_err   (range_err)
`ifdef CELL_REASSIGN_STATS_EN
        ,
        .stat_acc       (stat_acc),
        .stat_drop      (stat_drop),
        .stat_null      (stat_null),
        .stat_acc_last  (stat_acc_last),
        .stat_drop_last (stat_drop_last),
        .stat_null_last (stat_null_last)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: fill bank, committed bank, sticky flags, protocol phase
    logic [95:0] m_wd [NCELL][DEPTH];
    logic [95:0] m_cd [NCELL][DEPTH];
    int          m_wn [NCELL];
    int          m_cn [NCELL];
    bit          m_ovf, m_rng;
    int          m_ph;
    int          m_acc, m_drop, m_null;

    task automatic model_clear();
        for (int c = 0; c < NCELL; c++) begin
            m_wn[c] = 0;
            m_cn[c] = 0;
        end
        m_ovf = 0; m_rng = 0; m_ph = 0;
        m_acc = 0; m_drop = 0; m_null = 0;
    endtask

    task automatic model_accept(input logic [32:0] c, input logic [95:0] p);
        int ci;
        if (c[32]) begin
            m_null++;
        end else if (c[31:0] >= 32'(NCELL)) begin
            m_rng = 1; m_drop++;
        end else begin
            ci = int'(c[31:0]);
            if (m_wn[ci] == DEPTH) begin
                m_ovf = 1; m_drop++;
            end else begin
                m_wd[ci][m_wn[ci]] = p;
                m_wn[ci]++;
                m_acc++;
            end
        end
    endtask

    task automatic model_swap();
        for (int c = 0; c < NCELL; c++) begin
            for (int s = 0; s < DEPTH; s++) m_cd[c][s] = m_wd[c][s];
            m_cn[c] = m_wn[c];
            m_wn[c] = 0;
        end
        m_acc = 0; m_drop = 0; m_null = 0;
    endtask

    task automatic drive_idle();
        in_valid = 0; in_cidx = '0; in_pos = '0;
        commit_req = 0; rd_en = 0; rd_cell = '0; rd_slot = '0;
    endtask

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic tick();
        logic        exp_rdy, acc, rq, pre_ovf, pre_rng, e_hit;
        int          rc, rs;
        logic [SW:0] e_cnt;
        logic [95:0] e_data;
        #1;
        exp_rdy = (m_ph == 0) && !commit_req;
        check("in_ready", in_ready, exp_rdy);
        check("commit_done", commit_done, m_ph == 2);
        acc = in_valid && exp_rdy;
        rq = rd_en; rc = int'(rd_cell); rs = int'(rd_slot);
        e_hit = 0; e_cnt = '0; e_data = '0;
        if (rc < NCELL) begin
            e_cnt = (SW+1)'(m_cn[rc]);
            e_hit = rs < m_cn[rc];
            if (e_hit) e_data = m_cd[rc][rs];
        end
        pre_ovf = m_ovf; pre_rng = m_rng;
        @(posedge clk);
        if (acc) model_accept(in_cidx, in_pos[95:0]);
        if (m_ph == 2) model_swap();
        m_ph = (m_ph == 0) ? (commit_req ? 1 : 0) : ((m_ph == 1) ? 2 : 0);
        #1;
        check("rd_valid", rd_valid, rq);
        if (rq) begin
            check("rd_hit", rd_hit, e_hit);
            check("rd_count", rd_count, e_cnt);
            check("rd_data", rd_data, e_data);
        end
        check("overflow", overflow, pre_ovf);
        check("range_err", range_err, pre_rng);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_commit_done", commit_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_hit", rd_hit, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_range_err", range_err, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [32:0] c, input logic [95:0] p);
        in_valid = 1; in_cidx = c; in_pos = {1'b0, p};
        tick();
        in_valid = 0;
    endtask

    task automatic read(input int c, input int s);
        rd_en = 1; rd_cell = 5'(c); rd_slot = SW'(s);
        tick();
        rd_en = 0;
    endtask

    task automatic do_commit();
        int lat;
        lat = -1;
        commit_req = 1;
        for (int i = 0; i < 8; i++) begin
            if (commit_done) begin
                lat = i;
                break;
            end
            tick();
            commit_req = 0;
        end
        check("commit_latency", lat, 2);
        if (lat >= 0) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1;
        drive_idle();
        #1;
        do_reset();

        // Read right after reset
        read(0, 0);
        check("t1_rd_valid", rd_valid, 1);
        check("t1_rd_hit", rd_hit, 0);
        check("t1_rd_count", rd_count, 0);
        check("t1_rd_data", rd_data, 0);

        // Three items into cell 5
        push(33'd5, 96'(32'h3F800000));
        push(33'd5, 96'(32'h40000000));
        push(33'd5, 96'(32'h40400000));
        do_commit();
        read(5, 0); check("t2_s0_x", rd_data[31:0], 32'h3F800000);
        read(5, 1); check("t2_s1_x", rd_data[31:0], 32'h40000000);
        read(5, 2); check("t2_s2_x", rd_data[31:0], 32'h40400000);
        check("t2_count", rd_count, 3);
        read(5, 3); check("t2_s3_hit", rd_hit, 0);

        // Overflow of cell 26
        for (int i = 0; i < 17; i++) push(33'd26, 96'(i + 1));
        tick();
        check("t3_overflow", overflow, 1);
        check("t3_range_clear", range_err, 0);
        do_commit();
        read(26, 15);
        check("t3_count", rd_count, 16);
        check("t3_slot15", rd_data, 96'd16);

        // Null and out-of-range items
        push(33'h1_0000_0000, 96'hDEAD);
        tick();
        check("t4_null_no_err", range_err, 0);
        push(33'd27, 96'hBEEF);
        tick();
        check("t4_range_err", range_err, 1);
        do_commit();
        read(0, 0);  check("t4_cnt0", rd_count, 0);
        read(26, 0); check("t4_cnt26", rd_count, 0);

        // Fill one bank while reading the other
        push(33'd7, 96'hA1);
        push(33'd7, 96'hA2);
        do_commit();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_cidx = 33'd7; in_pos = 97'(96'hB1 + 96'(i));
            rd_en = 1; rd_cell = 5'd7; rd_slot = 4'd1;
            tick();
            check("t5_old_bank", rd_data, 96'hA2);
        end
        drive_idle();
        do_commit();
        read(7, 1);
        check("t5_new_bank", rd_data, 96'hB2);
        check("t5_new_count", rd_count, 3);

        // Randomized streaming with held commit requests and random reads
        for (int n = 0; n < 1500; n++) begin
            int r;
            in_valid = ($urandom_range(0, 9) < 7);
            r = int'($urandom_range(0, 19));
            if (r < 2)      in_cidx = {1'b1, $urandom()};
            else if (r < 4) in_cidx = {1'b0, 32'($urandom_range(27, 1000))};
            else if (r < 12) in_cidx = 33'($urandom_range(0, 3));
            else            in_cidx = 33'($urandom_range(0, NCELL - 1));
            in_pos = {1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 24) == 0) commit_req = ~commit_req;
            rd_en   = $urandom_range(0, 1);
            rd_cell = 5'($urandom_range(0, 31));
            rd_slot = SW'($urandom_range(0, DEPTH - 1));
            tick();
            if (n == 900) begin
                do_reset();
                read(0, 0);
                check("t7_reset_count", rd_count, 0);
            end
        end
        drive_idle();
        tick();
        tick();
`ifdef CELL_REASSIGN_STATS_EN
        check("stat_acc", stat_acc, 32'(m_acc));
        check("stat_drop", stat_drop, 32'(m_drop));
        check("stat_null", stat_null, 32'(m_null));
`endif
        do_commit();
        for (int c = 0; c < NCELL; c++) read(c, int'($urandom_range(0, DEPTH - 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
